// File: rtl/video_pkg.sv
// Shared types for the VGA/LCD video output stage.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } vga_state_t;

endpackage

// File: rtl/video_if.sv
// Pixel-FIFO handshake plus the registered video pins of the output stage.
interface video_if;
  import video_pkg::*;

  // Handshake: pix_data is taken on every rising edge where pix_ready is high.
  // pix_ready depends only on scan position, never on pix_valid; a high
  // pix_ready with low pix_valid is an underflow and the pixel is shown black.
  rgb_t       pix_data;
  logic       pix_valid;
  logic       pix_ready;

  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       frame_start;
  logic       underflow;

  modport master (
    input  pix_data, pix_valid,
    output pix_ready, VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
           frame_start, underflow
  );

  modport slave (
    output pix_data, pix_valid,
    input  pix_ready, VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B,
           frame_start, underflow
  );

endinterface

// File: rtl/sync_counter.sv
// One timing axis: counter laid out as front porch, sync, back porch, active.
module sync_counter #(
  parameter  int DISP  = 800,
  parameter  int FP    = 40,
  parameter  int PULSE = 48,
  parameter  int BP    = 40,
  localparam int TOTAL = FP + PULSE + BP + DISP,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cnt_en,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync_n,
  output logic         active
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(FP);
  localparam logic [W-1:0] SYNC_HI = W'(FP + PULSE);
  localparam logic [W-1:0] ACT_LO  = W'(FP + PULSE + BP);

  assign wrap   = (cnt == LAST);
  assign sync_n = !((cnt >= SYNC_LO) && (cnt < SYNC_HI));
  assign active = (cnt >= ACT_LO);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/LCD timing generator: scans HS/VS/BLANK and pulls one pixel per active
// position from the upstream FIFO, presenting everything on registered pins.
module vga_timing_gen
  import video_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic       pixel_clk,
  input  logic       pixel_rst_n,
  input  logic       enable,
  video_if.master    vid,
  output vga_state_t dbg_state
);

  localparam int HBLK = HFP + HPULSE + HBP;
  localparam int VBLK = VFP + VPULSE + VBP;
  localparam int HW   = $clog2(HBLK + HDISP);
  localparam int VW   = $clog2(VBLK + VDISP);

  vga_state_t    state;
  logic          run;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, h_sync_n, h_active;
  logic          v_wrap, v_sync_n, v_active;
  logic          frame_first;
  logic          frame_end;

  assign run       = (state == ST_RUN);
  assign dbg_state = state;

  sync_counter #(.DISP(HDISP), .FP(HFP), .PULSE(HPULSE), .BP(HBP)) u_h_cnt (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .cnt_en (run),
    .clear  (!run),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .sync_n (h_sync_n),
    .active (h_active)
  );

  sync_counter #(.DISP(VDISP), .FP(VFP), .PULSE(VPULSE), .BP(VBP)) u_v_cnt (
    .clk    (pixel_clk),
    .rst_n  (pixel_rst_n),
    .cnt_en (run && h_wrap),
    .clear  (!run),
    .cnt    (v_cnt),
    .wrap   (v_wrap),
    .sync_n (v_sync_n),
    .active (v_active)
  );

  assign vid.pix_ready = run && h_active && v_active;
  assign frame_first   = (h_cnt == HW'(HBLK)) && (v_cnt == VW'(VBLK));
  assign frame_end     = h_wrap && v_wrap;

  // Outputs follow the counter state by one cycle; leaving RUN only at the
  // frame wrap means a disabled scan never truncates a frame.
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      state           <= ST_IDLE;
      vid.VGA_HS      <= 1'b1;
      vid.VGA_VS      <= 1'b1;
      vid.VGA_BLANK   <= 1'b0;
      vid.VGA_R       <= 8'h00;
      vid.VGA_G       <= 8'h00;
      vid.VGA_B       <= 8'h00;
      vid.frame_start <= 1'b0;
      vid.underflow   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (enable) state <= ST_WAIT;
        ST_WAIT: begin
          if (!enable)            state <= ST_IDLE;
          else if (vid.pix_valid) state <= ST_RUN;
        end
        ST_RUN:  if (!enable && frame_end) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      vid.VGA_HS      <= !run || h_sync_n;
      vid.VGA_VS      <= !run || v_sync_n;
      vid.VGA_BLANK   <= vid.pix_ready;
      vid.frame_start <= vid.pix_ready && frame_first;

      if (vid.pix_ready && vid.pix_valid) begin
        vid.VGA_R <= vid.pix_data.r;
        vid.VGA_G <= vid.pix_data.g;
        vid.VGA_B <= vid.pix_data.b;
      end else begin
        vid.VGA_R <= 8'h00;
        vid.VGA_G <= 8'h00;
        vid.VGA_B <= 8'h00;
      end

      if (vid.pix_ready && !vid.pix_valid) vid.underflow <= 1'b1;
    end
  end

endmodule
